// File: rtl/output_byte_transmitter.sv
// OUTPUTB byte sink: buffers bytes from decode in a FIFO and
// serializes them onto the UART TX line as 8N1 frames.
module output_byte_transmitter #(
  parameter logic [5:0] OUTPUTB      = 6'b111110,
  parameter int         DEPTH_LOG2   = 4,
  parameter int         CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  input  logic [7:0]  data,
  output logic        freeze,
  output logic        tx,
  output logic        tx_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic accept, full, empty, push, pop, baud_end;
  logic unused_inst;

  assign unused_inst = ^inst[25:0];

  assign accept = inst_valid && (inst[31:26] == OUTPUTB);
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  assign freeze = accept && full;
  assign push   = accept && !full;

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push && !pop: count_d = count_q + 1'b1;
      pop && !push: count_d = count_q - 1'b1;
      default:      count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign baud_end = (baud_q == BAUD_LAST);

  // STOP chains straight into the next START when data is waiting
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_output_byte_transmitter.sv
// Scoreboard bench: bytes queued on push, decoded off tx and
// compared; frame timing and freeze behaviour checked directly.
module tb_output_byte_transmitter;

  localparam logic [5:0] OP  = 6'b111110;
  localparam logic [5:0] NOP = 6'b111101;

  logic        clk;
  logic        reset;
  logic [31:0] inst;
  logic        inst_valid;
  logic [7:0]  data;
  logic        freeze;
  logic        tx;
  logic        tx_busy;

  int vecs = 0;
  int errs = 0;
  logic [7:0] sb [$];

  output_byte_transmitter #(
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inst      (inst),
    .inst_valid(inst_valid),
    .data      (data),
    .freeze    (freeze),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    inst       = {OP, 26'($urandom)};
    inst_valid = 1'b1;
    data       = b;
    sb.push_back(b);
  endtask

  task automatic idle_in();
    inst_valid = 1'b0;
    inst       = '0;
    data       = 8'($urandom);
  endtask

  // counts negedges from first low tx until tx_busy drops
  task automatic frame_len(input string tag, input int exp);
    int w = 0;
    int n = 0;
    while (tx !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    while (tx_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, exp);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle", tx_busy, 1'b0);
  endtask

  // frame decoder sampling mid-bit at 4 clocks per bit
  initial begin
    bit   act = 1'b0;
    int   cnt = 0;
    logic [7:0] sh = '0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        act = 1'b0;
      end else begin
        if (!act && tx === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
        if (act) begin
          if (cnt == 2) chk("start_bit", tx, 1'b0);
          else if (cnt >= 6 && cnt <= 34 && (cnt - 6) % 4 == 0)
            sh[(cnt-6)/4] = tx;
          else if (cnt == 38) begin
            chk("stop_bit", tx, 1'b1);
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
              exp = sb.pop_front();
              chk("byte", sh, exp);
            end
          end
          if (cnt == 39) act = 1'b0;
          cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    idle_in();
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    drive(8'hA5);
    @(negedge clk);
    idle_in();
    chk("lat_tx", tx, 1'b1);
    chk("lat_busy", tx_busy, 1'b1);
    frame_len("len_single", 40);

    for (int i = 0; i < 4; i++) begin
      inst = {NOP, 26'($urandom)};
      inst_valid = 1'b1;
      data = 8'hFF;
      @(negedge clk);
      chk("nop_freeze", freeze, 1'b0);
      chk("nop_tx", tx, 1'b1);
      chk("nop_busy", tx_busy, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      inst = {OP, 26'($urandom)};
      inst_valid = 1'b0;
      data = 8'hFF;
      @(negedge clk);
      chk("inv_freeze", freeze, 1'b0);
      chk("inv_tx", tx, 1'b1);
      chk("inv_busy", tx_busy, 1'b0);
    end
    idle_in();
    @(negedge clk);

    fork
      begin
        drive(8'h01); @(negedge clk);
        drive(8'h02); @(negedge clk);
        drive(8'h03); @(negedge clk);
        idle_in();
      end
      frame_len("len_b2b", 120);
    join

    for (int i = 0; i <= 16; i++) begin
      drive(8'(i));
      #1 chk("fill_freeze", freeze, 1'b0);
      @(negedge clk);
    end
    inst = {OP, 26'($urandom)};
    inst_valid = 1'b1;
    data = 8'h11;
    #1 chk("full_freeze", freeze, 1'b1);
    n = 0;
    while (freeze === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("frozen_cycles", n, 25);
    sb.push_back(8'h11);
    @(negedge clk);
    idle_in();
    #1 chk("unfrozen", freeze, 1'b0);
    wait_idle(900);
    @(negedge clk);

    fork
      begin
        drive(8'hC3); @(negedge clk);
        drive(8'h3C); @(negedge clk);
        idle_in();
        repeat (39) @(negedge clk);
        drive(8'h96); @(negedge clk);
        idle_in();
      end
      frame_len("len_simul", 120);
    join

    drive(8'h5A); @(negedge clk);
    drive(8'h5B); @(negedge clk);
    drive(8'h5C); @(negedge clk);
    idle_in();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_freeze", freeze, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_busy", tx_busy, 1'b0);
      chk("post_rst_tx", tx, 1'b1);
    end

    drive(8'h81);
    @(negedge clk);
    idle_in();
    frame_len("len_after_rst", 40);
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/output_byte_transmitter.md
Name: output_byte_transmitter

Overview:
- Output-side counterpart to the pipeline's input-wait logic; executes the OUTPUTB instruction.
- Accepts one byte per OUTPUTB from the decode stage into a FIFO and serializes FIFO contents onto the UART TX line as 8N1 frames.
- Raises a combinational freeze to the pipeline while an OUTPUTB is presented and the FIFO is full.

Parameters:
- OUTPUTB, 6'b111110, opcode (inst[31:26]) of the byte-output instruction.
- DEPTH_LOG2, 4, log2 of FIFO depth. Default gives 16 entries.
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200). Legal range 2..65535.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- inst  input  32  instruction in the decode stage.
- inst_valid  input  1  inst is live and not stalled by any other source this cycle.
- data  input  8  byte to output (low byte of the source register).
- freeze  output  1  pipeline stall request.
- tx  output  1  UART serial line, idle high.
- tx_busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset (async, immediate): FIFO pointers=0, count=0, state=IDLE, bit counter=0, baud counter=0, tx=1.
- Outputs under reset: freeze=0, tx_busy=0.
- Accept condition: inst[31:26]==OUTPUTB && inst_valid.
- freeze is combinational: accept condition && count==2^DEPTH_LOG2.
  - freeze uses the registered count only; a pop in the same cycle does not clear it.
- Push: on accept condition && !full, data is written at the rising edge and count increments. Exactly one push per accepted cycle; a frozen cycle pushes nothing.
- count is DEPTH_LOG2+1 bits. Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Transmitter FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If count!=0, pop the head byte into the shift register, set tx=0, go to START, baud counter=0.
  - Otherwise tx=1.
- START: hold tx=0 for CLKS_PER_BIT cycles. Then set tx=shift[0], go to DATA, bit counter=0.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first.
  - After the bit-7 period, set tx=1 and go to STOP.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. At the end of the period:
  - If count!=0, pop immediately, set tx=0 and go to START (no idle gap).
  - Otherwise go to IDLE.
- Latency: a byte pushed at edge N into an empty, idle block drives tx low from edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- tx is a registered output (glitch-free).
- tx_busy = (state!=IDLE) || (count!=0), registered or derived from registered state only.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, 16 bits wide.
- Reset mid-frame: the line returns high immediately and FIFO contents are discarded. The partial frame is not resumed.
- data is sampled only on a push edge; changes at other times have no effect.

Test Plan:
- Reset check (CLKS_PER_BIT=4): assert reset mid-simulation -> tx=1, freeze=0, tx_busy=0 the same cycle, before any clock edge.
- Single byte: one accepted OUTPUTB with data=8'hA5 at edge N.
  - tx=0 over cycles N+1..N+4.
  - Then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop 1 for 4 cycles.
  - tx_busy drops after 40 cycles.
- Non-OUTPUTB or inst_valid=0: present opcode 6'b111101 or inst_valid=0 with data=8'hFF -> no push, tx stays 1, freeze=0.
- Back-to-back: push 8'h01, 8'h02, 8'h03 on consecutive cycles -> three frames with no idle cycle between stop and next start; total 120 cycles.
- Full FIFO: push 17 bytes 8'h00..8'h10 on consecutive cycles.
  - The first pushed byte pops at edge N+1.
  - 8'h10 is accepted when count reaches 15 after that pop.
  - An 18th OUTPUTB asserts freeze and stays frozen until the next pop; it is then accepted once.
  - Serial output order is 8'h00..8'h11 with no loss or duplication.
- Simultaneous push and pop: push on the exact cycle the STOP period ends with count=1 -> count stays 1, the popped byte starts, and the new byte is preserved.
